// File: rtl/umi_merger.sv
// ---------------------------------------------------------------------------
// umi_merger
//
// Two-input UMI merge stage: a response stream and a request stream are
// combined into a single UMI stream (e.g. for one shared physical link).
// It is the architectural inverse of umi_splitter, which sits directly
// downstream of it.
//
// Arbitration is round-robin with one beat per transaction. Accepted
// packets are held in a 2-entry FIFO that drives the output, so the input
// ready signals depend only on registered state and the input valids. They
// never depend on umi_out_ready, which keeps the ready path free of any
// combinational loop through the downstream block.
//
// Parameters:
//   DW - data width, AW - address width (dstaddr/srcaddr), CW - command width
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   umi_resp_in_*         response input (valid/cmd/dstaddr/srcaddr/data, ready)
//   umi_req_in_*          request input  (valid/cmd/dstaddr/srcaddr/data, ready)
//   umi_out_*             merged output  (valid/cmd/dstaddr/srcaddr/data, ready)
// ---------------------------------------------------------------------------
module umi_merger #(
  parameter int DW = 256,
  parameter int AW = 64,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          umi_resp_in_valid,
  input  logic [CW-1:0] umi_resp_in_cmd,
  input  logic [AW-1:0] umi_resp_in_dstaddr,
  input  logic [AW-1:0] umi_resp_in_srcaddr,
  input  logic [DW-1:0] umi_resp_in_data,
  output logic          umi_resp_in_ready,

  input  logic          umi_req_in_valid,
  input  logic [CW-1:0] umi_req_in_cmd,
  input  logic [AW-1:0] umi_req_in_dstaddr,
  input  logic [AW-1:0] umi_req_in_srcaddr,
  input  logic [DW-1:0] umi_req_in_data,
  output logic          umi_req_in_ready,

  output logic          umi_out_valid,
  output logic [CW-1:0] umi_out_cmd,
  output logic [AW-1:0] umi_out_dstaddr,
  output logic [AW-1:0] umi_out_srcaddr,
  output logic [DW-1:0] umi_out_data,
  input  logic          umi_out_ready
);

  // Identity of the input that won the most recent accepted push.
  localparam logic GRANT_RESP = 1'b0;
  localparam logic GRANT_REQ  = 1'b1;

  localparam logic [1:0] COUNT_FULL = 2'd2;

  // Registered state
  logic [1:0]    count;
  logic          wr_ptr;
  logic          rd_ptr;
  logic          last_grant;

  // FIFO storage, one array per field
  logic [CW-1:0] cmd_mem     [2];
  logic [AW-1:0] dstaddr_mem [2];
  logic [AW-1:0] srcaddr_mem [2];
  logic [DW-1:0] data_mem    [2];

  // Combinational control
  logic          can_accept;
  logic          grant_resp;
  logic          grant_req;
  logic          push_resp;
  logic          push_req;
  logic          push;
  logic          pop;

  // Selected write payload
  logic [CW-1:0] push_cmd;
  logic [AW-1:0] push_dstaddr;
  logic [AW-1:0] push_srcaddr;
  logic [DW-1:0] push_data;

  // Space is judged from the registered count only; a pop in the same cycle
  // is deliberately not credited so that ready stays independent of
  // umi_out_ready.
  assign can_accept = (count != COUNT_FULL);

  // A lone requester always wins. Under contention the side that did not
  // win the last accepted push goes first.
  assign grant_resp = umi_resp_in_valid &&
                      (!umi_req_in_valid || (last_grant == GRANT_REQ));
  assign grant_req  = umi_req_in_valid && !grant_resp;

  // The rst term keeps both readies low during the reset cycle even though
  // the registered count has not yet been cleared.
  assign umi_resp_in_ready = !rst && can_accept && grant_resp;
  assign umi_req_in_ready  = !rst && can_accept && grant_req;

  assign push_resp = umi_resp_in_valid && umi_resp_in_ready;
  assign push_req  = umi_req_in_valid  && umi_req_in_ready;
  assign push      = push_resp || push_req;

  assign umi_out_valid = (count != 2'd0);
  assign pop           = umi_out_valid && umi_out_ready;

  // Payload multiplexer: at most one input is ever granted, so selecting on
  // push_req alone is sufficient.
  always_comb begin
    push_cmd     = umi_resp_in_cmd;
    push_dstaddr = umi_resp_in_dstaddr;
    push_srcaddr = umi_resp_in_srcaddr;
    push_data    = umi_resp_in_data;
    if (push_req) begin
      push_cmd     = umi_req_in_cmd;
      push_dstaddr = umi_req_in_dstaddr;
      push_srcaddr = umi_req_in_srcaddr;
      push_data    = umi_req_in_data;
    end
  end

  // Occupancy, pointers and arbitration history. A simultaneous push and pop
  // leaves the count unchanged while both pointers advance, which gives
  // one packet per cycle in steady state.
  always_ff @(posedge clk) begin
    if (rst) begin
      count      <= 2'd0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      last_grant <= GRANT_REQ;
    end else begin
      if (push) begin
        wr_ptr     <= ~wr_ptr;
        last_grant <= push_req ? GRANT_REQ : GRANT_RESP;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Payload storage carries no reset: entries are only observed once the
  // count marks them as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      cmd_mem[wr_ptr]     <= push_cmd;
      dstaddr_mem[wr_ptr] <= push_dstaddr;
      srcaddr_mem[wr_ptr] <= push_srcaddr;
      data_mem[wr_ptr]    <= push_data;
    end
  end

  // The output always shows the FIFO head. It stays stable while stalled
  // because rd_ptr only moves on a pop.
  assign umi_out_cmd     = cmd_mem[rd_ptr];
  assign umi_out_dstaddr = dstaddr_mem[rd_ptr];
  assign umi_out_srcaddr = srcaddr_mem[rd_ptr];
  assign umi_out_data    = data_mem[rd_ptr];

endmodule

// File: tb/tb_umi_merger.sv
// ---------------------------------------------------------------------------
// tb_umi_merger
//
// Self-checking bench for umi_merger. A stimulus process drives both input
// streams and the downstream ready, and pushes every packet that the
// reference arbitration says should be accepted into an expected queue. A
// separate monitor process compares the DUT output against the head of
// that queue and pops it whenever the output is consumed.
// ---------------------------------------------------------------------------
module tb_umi_merger;

  localparam int DW = 256;
  localparam int AW = 64;
  localparam int CW = 32;

  typedef struct packed {
    logic [CW-1:0] cmd;
    logic [AW-1:0] dstaddr;
    logic [AW-1:0] srcaddr;
    logic [DW-1:0] data;
  } pkt_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;

  logic          umi_resp_in_valid = 1'b0;
  logic [CW-1:0] umi_resp_in_cmd = '0;
  logic [AW-1:0] umi_resp_in_dstaddr = '0;
  logic [AW-1:0] umi_resp_in_srcaddr = '0;
  logic [DW-1:0] umi_resp_in_data = '0;
  logic          umi_resp_in_ready;

  logic          umi_req_in_valid = 1'b0;
  logic [CW-1:0] umi_req_in_cmd = '0;
  logic [AW-1:0] umi_req_in_dstaddr = '0;
  logic [AW-1:0] umi_req_in_srcaddr = '0;
  logic [DW-1:0] umi_req_in_data = '0;
  logic          umi_req_in_ready;

  logic          umi_out_valid;
  logic [CW-1:0] umi_out_cmd;
  logic [AW-1:0] umi_out_dstaddr;
  logic [AW-1:0] umi_out_srcaddr;
  logic [DW-1:0] umi_out_data;
  logic          umi_out_ready = 1'b0;

  always #5 clk = ~clk;

  umi_merger #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .umi_resp_in_valid   (umi_resp_in_valid),
    .umi_resp_in_cmd     (umi_resp_in_cmd),
    .umi_resp_in_dstaddr (umi_resp_in_dstaddr),
    .umi_resp_in_srcaddr (umi_resp_in_srcaddr),
    .umi_resp_in_data    (umi_resp_in_data),
    .umi_resp_in_ready   (umi_resp_in_ready),
    .umi_req_in_valid    (umi_req_in_valid),
    .umi_req_in_cmd      (umi_req_in_cmd),
    .umi_req_in_dstaddr  (umi_req_in_dstaddr),
    .umi_req_in_srcaddr  (umi_req_in_srcaddr),
    .umi_req_in_data     (umi_req_in_data),
    .umi_req_in_ready    (umi_req_in_ready),
    .umi_out_valid       (umi_out_valid),
    .umi_out_cmd         (umi_out_cmd),
    .umi_out_dstaddr     (umi_out_dstaddr),
    .umi_out_srcaddr     (umi_out_srcaddr),
    .umi_out_data        (umi_out_data),
    .umi_out_ready       (umi_out_ready)
  );

  // Reference model state: expected FIFO contents in acceptance order and
  // which side won the last accepted push (0 = resp, 1 = req).
  pkt_t model_q[$];
  logic model_last = 1'b1;
  logic mon_en = 1'b0;

  int checks = 0;
  int errors = 0;

  // Source state: a source holds its packet until it is accepted.
  logic r_v = 1'b0;
  logic q_v = 1'b0;
  pkt_t r_p = '0;
  pkt_t q_p = '0;

  function automatic void checkOutput(input string name, input logic [DW-1:0] actual,
                                      input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endfunction

  function automatic pkt_t randPkt();
    pkt_t p;
    p.cmd     = $urandom;
    p.dstaddr = {$urandom, $urandom};
    p.srcaddr = {$urandom, $urandom};
    for (int i = 0; i < DW / 32; i++) p.data[i*32 +: 32] = $urandom;
    return p;
  endfunction

  // One clock cycle of stimulus: drive at the falling edge, check the
  // readies just after, and update the model at the rising edge.
  task automatic applyStimulus(input logic rv, input pkt_t rp, input logic qv, input pkt_t qp,
                               input logic ordy, input logic rs,
                               output logic r_acc, output logic q_acc);
    logic exp_r;
    logic exp_q;
    @(negedge clk);
    rst                 = rs;
    umi_resp_in_valid   = rv;
    umi_resp_in_cmd     = rp.cmd;
    umi_resp_in_dstaddr = rp.dstaddr;
    umi_resp_in_srcaddr = rp.srcaddr;
    umi_resp_in_data    = rp.data;
    umi_req_in_valid    = qv;
    umi_req_in_cmd      = qp.cmd;
    umi_req_in_dstaddr  = qp.dstaddr;
    umi_req_in_srcaddr  = qp.srcaddr;
    umi_req_in_data     = qp.data;
    umi_out_ready       = ordy;
    #1;
    exp_r = !rs && (model_q.size() < 2) && rv && (!qv || model_last);
    exp_q = !rs && (model_q.size() < 2) && qv && !exp_r;
    checkOutput("resp_in_ready", DW'(umi_resp_in_ready), DW'(exp_r));
    checkOutput("req_in_ready", DW'(umi_req_in_ready), DW'(exp_q));
    @(posedge clk);
    if (rs) begin
      model_q.delete();
      model_last = 1'b1;
    end else if (exp_r) begin
      model_q.push_back(rp);
      model_last = 1'b0;
    end else if (exp_q) begin
      model_q.push_back(qp);
      model_last = 1'b1;
    end
    r_acc = exp_r;
    q_acc = exp_q;
  endtask

  // Runs a number of cycles of held-valid traffic. ordy_mode: 0 low,
  // 1 high, 2 toggling, 3 random. At most max_new new packets are created.
  task automatic runTraffic(input int cycles, input int ordy_mode, input int resp_pct,
                            input int req_pct, input int max_new);
    int   created;
    logic ra;
    logic qa;
    logic ordy;
    created = 0;
    for (int c = 0; c < cycles; c++) begin
      if (!r_v && created < max_new && $urandom_range(99) < resp_pct) begin
        r_v = 1'b1;
        r_p = randPkt();
        created++;
      end
      if (!q_v && created < max_new && $urandom_range(99) < req_pct) begin
        q_v = 1'b1;
        q_p = randPkt();
        created++;
      end
      case (ordy_mode)
        0:       ordy = 1'b0;
        1:       ordy = 1'b1;
        2:       ordy = c[0];
        default: ordy = 1'($urandom_range(1));
      endcase
      applyStimulus(r_v, r_p, q_v, q_p, ordy, 1'b0, ra, qa);
      if (ra) r_v = 1'b0;
      if (qa) q_v = 1'b0;
    end
  endtask

  // Monitor: compares the output against the expected head and retires it
  // when the downstream consumes it.
  initial begin
    logic do_pop;
    forever begin
      @(negedge clk);
      #2;
      do_pop = 1'b0;
      if (mon_en) begin
        checkOutput("out_valid", DW'(umi_out_valid), DW'(model_q.size() != 0));
        if (model_q.size() != 0) begin
          checkOutput("out_cmd", DW'(umi_out_cmd), DW'(model_q[0].cmd));
          checkOutput("out_dstaddr", DW'(umi_out_dstaddr), DW'(model_q[0].dstaddr));
          checkOutput("out_srcaddr", DW'(umi_out_srcaddr), DW'(model_q[0].srcaddr));
          checkOutput("out_data", umi_out_data, model_q[0].data);
          do_pop = umi_out_ready && !rst;
        end
      end
      @(posedge clk);
      if (do_pop) void'(model_q.pop_front());
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    pkt_t p;
    pkt_t dummy;
    logic ra;
    logic qa;
    int   waited;

    dummy = randPkt();
    $display("[TB] reset");
    applyStimulus(1'b1, dummy, 1'b1, dummy, 1'b0, 1'b1, ra, qa);
    applyStimulus(1'b1, dummy, 1'b1, dummy, 1'b0, 1'b1, ra, qa);
    mon_en = 1'b1;

    $display("[TB] single resp packet");
    p = '0;
    p.cmd     = 32'h0000_000B;
    p.dstaddr = 64'h10;
    p.data    = 256'hAA;
    applyStimulus(1'b1, p, 1'b0, dummy, 1'b1, 1'b0, ra, qa);
    runTraffic(3, 1, 0, 0, 0);

    $display("[TB] continuous contention");
    runTraffic(8, 1, 100, 100, 8);
    runTraffic(4, 1, 0, 0, 0);

    $display("[TB] stalled output");
    runTraffic(4, 0, 100, 100, 3);
    runTraffic(6, 1, 0, 0, 0);

    $display("[TB] reset with full fifo");
    runTraffic(3, 0, 100, 100, 4);
    applyStimulus(r_v, r_p, q_v, q_p, 1'b0, 1'b1, ra, qa);
    runTraffic(5, 1, 0, 0, 0);

    $display("[TB] request only then contention");
    runTraffic(8, 1, 0, 100, 5);
    runTraffic(6, 1, 100, 100, 4);
    runTraffic(4, 1, 0, 0, 0);

    $display("[TB] random traffic");
    runTraffic(300, 2, 50, 50, 1000);
    runTraffic(300, 3, 70, 70, 1000);

    waited = 0;
    while ((model_q.size() != 0 || r_v || q_v) && waited < 64) begin
      runTraffic(1, 1, 0, 0, 0);
      waited++;
    end
    if (waited >= 64) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", model_q.size());
    end
    applyStimulus(1'b0, dummy, 1'b0, dummy, 1'b1, 1'b0, ra, qa);
    @(negedge clk);
    #3;
    checkOutput("final_out_valid", DW'(umi_out_valid), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/umi_merger.md
Name: umi_merger

Overview:
- Two-input UMI merge stage. It sits directly upstream of umi_splitter and is its architectural inverse.
- Combines a response stream and a request stream into one UMI stream, for example for a single shared link.
- Arbitration is round-robin and single-beat per transaction.
- The output is buffered by a 2-entry FIFO. Input-ready depends only on registered state and the input valids, never on umi_out_ready.

Parameters:
- DW, 256, UMI data width in bits
- AW, 64, UMI address width (dstaddr/srcaddr)
- CW, 32, UMI command width

Ports:
- clk  input  1  single clock; all state on rising edge
- rst  input  1  synchronous, active-high reset
- umi_resp_in_valid  input  1  response input valid
- umi_resp_in_cmd  input  CW  response command
- umi_resp_in_dstaddr  input  AW  response destination address
- umi_resp_in_srcaddr  input  AW  response source address
- umi_resp_in_data  input  DW  response data
- umi_resp_in_ready  output  1  response input accepted
- umi_req_in_valid / _cmd / _dstaddr / _srcaddr / _data  input  1/CW/AW/AW/DW  request input, same meaning as the response input
- umi_req_in_ready  output  1  request input accepted
- umi_out_valid  output  1  merged output valid
- umi_out_cmd / _dstaddr / _srcaddr / _data  output  CW/AW/AW/DW  merged packet fields
- umi_out_ready  input  1  downstream ready

Behaviour:
- Transfer: a transfer occurs on a port when valid && ready at the rising clk edge. Once a source raises valid, it holds valid and its fields stable until the transfer.
- Storage: 2-entry FIFO of {cmd, dstaddr, srcaddr, data}, with a registered occupancy count of 0..2.
- can_accept = (count < 2). It is derived from registered state only.
- Grant (combinational):
  - Only one input valid: that input is granted.
  - Both valid: the input not granted at the last accepted push wins.
  - last_grant updates only on an accepted push.
- Ready outputs:
  - umi_resp_in_ready = can_accept && grant==RESP.
  - umi_req_in_ready = can_accept && grant==REQ.
  - At most one ready is high per cycle.
  - Neither ready depends on umi_out_ready.
- Output:
  - umi_out_valid = (count != 0).
  - Fields come from the FIFO head.
  - The head stays stable while umi_out_valid && !umi_out_ready.
- Latency: an input accepted in cycle N appears on the output in cycle N+1 at the earliest.
- Throughput: 1 packet/cycle in steady state (count 1, push and pop in the same cycle).
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop: unchanged; the FIFO write/read pointers both advance
  - push at count 2 is impossible because can_accept is low
  - pop at count 0 is impossible because valid is low
- Order: output order equals acceptance order; no reordering.
- Reset (rst=1 sampled at a rising edge):
  - count=0, pointers=0, umi_out_valid=0.
  - last_grant=REQ, so RESP wins the first contention.
  - Both in_ready are 0 during the reset cycle.
  - Output data fields are don't-care while valid=0.
- Reset mid-operation discards all buffered packets; no partial output.
- Fields pass through untouched; no cmd decode or modification.

Test Plan:
- Single resp packet (cmd=0x0000_000B, dstaddr=0x10, data=0xAA) with req idle -> resp_in_ready=1 in the same cycle; umi_out_valid=1 one cycle later with identical fields.
- Both inputs valid continuously, out_ready=1 -> accepted order RESP, REQ, RESP, REQ...; 8 packets emitted in 8 consecutive cycles after a 1-cycle latency.
- out_ready=0 with 3 packets offered -> 2 accepted, count=2, both in_ready=0. Raise out_ready -> packets emitted in acceptance order, the third is accepted the cycle after the first pop.
- out_ready toggling each cycle with random valids on both inputs; scoreboard per source -> no loss, no duplication, per-source order preserved, out fields stable while stalled.
- Assert rst with count=2 -> next cycle umi_out_valid=0 and count=0. The first post-reset contention grants RESP.
- Req only valid for 5 packets, then both valid -> RESP is granted next, since last_grant=REQ.
